// File: rtl/ixc_gfifo_opack.sv
// Packs 1..16-lane chunks into 256-bit words, 1-cycle latency; inReady drops at fill>8 or while a flush drains.
// Tail pad lanes are zero, or 32'hA5A5_0000|lane when IXC_OPACK_PAD_MARK_EN is defined.
module ixc_gfifo_opack #(
  parameter int LANE_W    = 32,
  parameter int IN_LANES  = 16,
  parameter int OUT_LANES = 8,
  parameter int ADDR_W    = 15,
  parameter int LEN_W     = 18
) (
  input  logic                         fclk,
  input  logic                         hssResetN,
  input  logic                         inValid,
  output logic                         inReady,
  input  logic [IN_LANES*LANE_W-1:0]   inData,
  input  logic [$clog2(IN_LANES)-1:0]  inLen,
  input  logic                         inFlush,
  output logic                         outValid,
  input  logic                         outReady,
  output logic [OUT_LANES*LANE_W-1:0]  outData,
  output logic [ADDR_W-1:0]            outAddr,
  output logic                         outLast,
  output logic                         doneValid,
  output logic [LEN_W-1:0]             doneLen,
  output logic                         ovfErr
);
  localparam int BUF_LANES = OUT_LANES + IN_LANES;
  localparam int BUF_W     = BUF_LANES * LANE_W;
  localparam int FILL_W    = $clog2(BUF_LANES + 1);
  localparam int SH_W      = $clog2(BUF_W + 1);

  logic [BUF_W-1:0]  buf_q, buf_d, buf_sh, ins_dat, ins_msk;
  logic [FILL_W-1:0] fill_q, fill_d, take, base, lanes;
  logic [SH_W-1:0]   sh_base, sh_keep;
  logic              flush_q, alive_q, done_vld_q, ovf_q;
  logic [LEN_W-1:0]  pkt_q, pkt_inc, done_len_q;
  logic [ADDR_W-1:0] addr_q;
  logic              in_hs, out_hs, full_word;
  logic [OUT_LANES*LANE_W-1:0] out_word;

  assign full_word = fill_q >= FILL_W'(OUT_LANES);
  assign inReady   = alive_q & (fill_q <= FILL_W'(OUT_LANES)) & ~flush_q;
  assign outValid  = full_word | (flush_q & (fill_q != '0));
  assign outLast   = flush_q & (fill_q <= FILL_W'(OUT_LANES));
  assign in_hs     = inValid & inReady;
  assign out_hs    = outValid & outReady;

  assign lanes  = (inLen == '0) ? FILL_W'(IN_LANES) : FILL_W'(inLen);
  assign take   = out_hs ? (full_word ? FILL_W'(OUT_LANES) : fill_q) : '0;
  assign base   = fill_q - take;
  assign fill_d = base + (in_hs ? lanes : '0);

  // A short tail word only drains under flush, when no chunk can arrive, so a fixed
  // one-word shift is always correct for the surviving lanes.
  assign sh_base = SH_W'(base) * SH_W'(LANE_W);
  assign sh_keep = SH_W'(FILL_W'(BUF_LANES) - lanes) * SH_W'(LANE_W);
  assign buf_sh  = out_hs ? (buf_q >> (OUT_LANES * LANE_W)) : buf_q;
  assign ins_dat = BUF_W'(inData) << sh_base;
  assign ins_msk = in_hs ? (({BUF_W{1'b1}} >> sh_keep) << sh_base) : '0;
  assign buf_d   = (buf_sh & ~ins_msk) | (ins_dat & ins_msk);

  always_comb begin
    out_word = '0;
    for (int j = 0; j < OUT_LANES; j++) begin
      if (full_word || (FILL_W'(j) < fill_q))
        out_word[j*LANE_W +: LANE_W] = buf_q[j*LANE_W +: LANE_W];
      else
`ifdef IXC_OPACK_PAD_MARK_EN
        out_word[j*LANE_W +: LANE_W] = LANE_W'(32'hA5A5_0000 | 32'(j));
`else
        out_word[j*LANE_W +: LANE_W] = '0;
`endif
    end
  end

  assign outData   = outValid ? out_word : '0;
  assign outAddr   = addr_q;
  assign doneValid = done_vld_q;
  assign doneLen   = done_len_q;
  assign ovfErr    = ovf_q;
  assign pkt_inc   = (pkt_q == '1) ? pkt_q : pkt_q + 1'b1;

  always_ff @(posedge fclk or negedge hssResetN) begin
    if (!hssResetN) begin
      buf_q      <= '0;
      fill_q     <= '0;
      flush_q    <= 1'b0;
      alive_q    <= 1'b0;
      pkt_q      <= '0;
      addr_q     <= '0;
      done_vld_q <= 1'b0;
      done_len_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      alive_q    <= 1'b1;
      buf_q      <= buf_d;
      fill_q     <= fill_d;
      done_vld_q <= 1'b0;
      if (in_hs && inFlush)
        flush_q <= 1'b1;
      if (out_hs) begin
        addr_q <= addr_q + 1'b1;
        if (pkt_inc == '1)
          ovf_q <= 1'b1;
        if (outLast) begin
          flush_q    <= 1'b0;
          pkt_q      <= '0;
          done_vld_q <= 1'b1;
          done_len_q <= pkt_inc;
        end else begin
          pkt_q <= pkt_inc;
        end
      end
    end
  end
endmodule

// File: tb/tb_ixc_gfifo_opack.sv
// Directed bench for ixc_gfifo_opack with a lane-level packing model feeding a word/done scoreboard.
module tb_ixc_gfifo_opack;
  typedef struct packed {
    logic [255:0] d;
    logic [14:0]  a;
    logic         l;
  } exp_t;

  logic         fclk = 1'b0;
  logic         hssResetN = 1'b0;
  logic         inValid = 1'b0, inReady, inFlush = 1'b0;
  logic [511:0] inData = '0;
  logic [3:0]   inLen = '0;
  logic         outValid, outReady = 1'b0, outLast, doneValid, ovfErr;
  logic [255:0] outData;
  logic [14:0]  outAddr;
  logic [17:0]  doneLen;

  int total = 0;
  int bad = 0;
  int lane_val = 1;
  int pkt_words = 0;
  bit mon_en = 1'b1;
  logic [14:0]  exp_addr = '0;
  logic [31:0]  pend[$];
  exp_t         exp_q[$];
  logic [17:0]  done_q[$];
  logic [511:0] cur_d;
  logic [255:0] snap;

  ixc_gfifo_opack dut (
    .fclk(fclk), .hssResetN(hssResetN), .inValid(inValid), .inReady(inReady),
    .inData(inData), .inLen(inLen), .inFlush(inFlush), .outValid(outValid),
    .outReady(outReady), .outData(outData), .outAddr(outAddr), .outLast(outLast),
    .doneValid(doneValid), .doneLen(doneLen), .ovfErr(ovfErr)
  );

  always #5 fclk = ~fclk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pad_val(input int j);
`ifdef IXC_OPACK_PAD_MARK_EN
    return 32'hA5A5_0000 | 32'(j);
`else
    return 32'(j) & 32'h0;
`endif
  endfunction

  // Reference packer: lanes accumulate; full words leave, a flush drains the remainder with pad.
  task automatic model_chunk(input int n, input bit fl, input logic [511:0] d);
    logic [255:0] w;
    bit last;
    for (int k = 0; k < n; k++) pend.push_back(d[k*32 +: 32]);
    while (pend.size() >= 8 || (fl && pend.size() > 0)) begin
      for (int j = 0; j < 8; j++)
        w[j*32 +: 32] = (pend.size() > 0) ? pend.pop_front() : pad_val(j);
      last = fl && (pend.size() == 0);
      exp_q.push_back('{d: w, a: exp_addr, l: last});
      exp_addr = exp_addr + 15'd1;
      pkt_words++;
    end
    if (fl) begin
      done_q.push_back(18'(pkt_words));
      pkt_words = 0;
    end
  endtask

  task automatic build(input int n, input bit fl);
    cur_d = '0;
    for (int k = 0; k < n; k++) begin
      cur_d[k*32 +: 32] = 32'(lane_val);
      lane_val++;
    end
    inData = cur_d; inLen = 4'(n); inFlush = fl; inValid = 1'b1;
  endtask

  task automatic accept(input int n, input bit fl);
    bit acc = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge fclk);
      if (inReady) begin acc = 1'b1; break; end
    end
    @(posedge fclk); #1;
    inValid = 1'b0; inFlush = 1'b0;
    chk("chunk_accept", 256'(acc), 256'(1'b1));
    if (acc) model_chunk(n, fl, cur_d);
  endtask

  task automatic send(input int n, input bit fl);
    build(n, fl);
    accept(n, fl);
  endtask

  task automatic drain();
    for (int c = 0; c < 200; c++) begin
      @(negedge fclk);
      if (exp_q.size() == 0 && done_q.size() == 0) break;
    end
    repeat (2) @(negedge fclk);
    chk("drain_words", 256'(exp_q.size()), 256'(0));
    chk("drain_done", 256'(done_q.size()), 256'(0));
  endtask

  always @(negedge fclk) begin
    exp_t e;
    if (mon_en && hssResetN) begin
      if (outValid && outReady) begin
        if (exp_q.size() == 0) chk("unexpected_word", 256'(outValid), 256'(1'b0));
        else begin
          e = exp_q.pop_front();
          chk("word_data", outData, e.d);
          chk("word_addr", 256'(outAddr), 256'(e.a));
          chk("word_last", 256'(outLast), 256'(e.l));
        end
      end
      if (doneValid) begin
        if (done_q.size() == 0) chk("unexpected_done", 256'(doneValid), 256'(1'b0));
        else chk("done_len", 256'(doneLen), 256'(done_q.pop_front()));
      end
    end
  end

  initial begin
    // reset state
    #12;
    chk("rst_inReady", 256'(inReady), 256'(1'b0));
    chk("rst_outValid", 256'(outValid), 256'(1'b0));
    chk("rst_outData", outData, 256'(0));
    chk("rst_outAddr", 256'(outAddr), 256'(0));
    chk("rst_outLast", 256'(outLast), 256'(1'b0));
    chk("rst_done", 256'({doneValid, doneLen, ovfErr}), 256'(0));
    @(posedge fclk); #1 hssResetN = 1'b1;
    repeat (2) @(negedge fclk);
    chk("post_rst_inReady", 256'(inReady), 256'(1'b1));
    @(posedge fclk); #1;

    // single 8-lane flush chunk, lanes 1..8
    outReady = 1'b1;
    send(8, 1'b1);
    @(negedge fclk);
    chk("t1_outValid", 256'(outValid), 256'(1'b1));
    chk("t1_outLast", 256'(outLast), 256'(1'b1));
    chk("t1_outAddr", 256'(outAddr), 256'(0));
    chk("t1_lane0", 256'(outData[31:0]), 256'(32'h1));
    drain();

    // 5+5+5+1 lanes: two full words, no pad
    @(posedge fclk); #1;
    send(5, 1'b0); send(5, 1'b0); send(5, 1'b0); send(1, 1'b1);
    drain();

    // 3-lane tail word
    @(posedge fclk); #1;
    send(3, 1'b1);
    drain();

    // back-pressure with 16-lane chunks
    @(posedge fclk); #1;
    outReady = 1'b0;
    send(16, 1'b0);
    build(16, 1'b0);
    @(negedge fclk);
    snap = outData;
    chk("bp_outValid", 256'(outValid), 256'(1'b1));
    for (int c = 0; c < 5; c++) begin
      @(negedge fclk);
      chk("bp_refused", 256'(inReady), 256'(1'b0));
      chk("bp_stable", outData, snap);
    end
    @(posedge fclk); #1 outReady = 1'b1;
    accept(16, 1'b0);
    send(4, 1'b1);
    drain();

    // reset mid-packet: fill=12, flush pending
    @(posedge fclk); #1;
    outReady = 1'b0;
    send(12, 1'b1);
    mon_en = 1'b0;
    hssResetN = 1'b0;
    #1;
    chk("mid_rst_outValid", 256'(outValid), 256'(1'b0));
    chk("mid_rst_outData", outData, 256'(0));
    chk("mid_rst_outAddr", 256'(outAddr), 256'(0));
    chk("mid_rst_last_done", 256'({outLast, doneValid, inReady}), 256'(0));
    @(posedge fclk); #1 hssResetN = 1'b1;
    pend.delete(); exp_q.delete(); done_q.delete();
    exp_addr = '0; pkt_words = 0;
    mon_en = 1'b1;
    outReady = 1'b1;
    repeat (10) @(negedge fclk);
    chk("mid_rst_idle", 256'(outValid), 256'(1'b0));

    // address wrap: 32766 words, then 3 more crossing 32767 -> 0
    @(posedge fclk); #1;
    for (int i = 0; i < 32766; i++) send(8, 1'b0);
    send(8, 1'b0); send(8, 1'b0); send(8, 1'b1);
    drain();
    chk("wrap_addr", 256'(outAddr), 256'(15'd1));
    chk("no_ovf", 256'(ovfErr), 256'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
